// File: rtl/blit_pkg.sv
// Shared constants, FSM state encoding and pipeline tag type for the sprite blitter.
package blit_pkg;

  localparam int FB_W             = 640;
  localparam int FB_H             = 480;
  localparam int FB_WORDS_PER_ROW = FB_W / 2;

  localparam int BIKE_W_WORDS  = 16;
  localparam int BIKE_H        = 32;
  localparam int TRAIL_W_WORDS = 2;
  localparam int TRAIL_H       = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } blit_state_t;

  // Position of one word inside the sprite, travelling alongside its RAM read.
  typedef struct packed {
    logic       valid;
    logic [4:0] row;
    logic [3:0] col;
  } blit_tag_t;

endpackage

// File: rtl/sprite_blitter_if.sv
// Draw-request, sprite-RAM read and frame-buffer write signals of the sprite blitter.
interface sprite_blitter_if;

  logic        start;
  logic [9:0]  pos_x;
  logic [8:0]  pos_y;
  logic [4:0]  spr_w_words;
  logic [5:0]  spr_h;
  logic        busy;
  logic        done;
  logic [19:0] spr_read_address;
  logic [15:0] spr_data;
  logic [18:0] fb_write_address;
  logic [15:0] fb_data;
  logic        fb_we;

  // master: game logic plus the sprite RAM data return; slave: the blitter.
  modport master (
    output start, pos_x, pos_y, spr_w_words, spr_h, spr_data,
    input  busy, done, spr_read_address, fb_write_address, fb_data, fb_we
  );

  modport slave (
    input  start, pos_x, pos_y, spr_w_words, spr_h, spr_data,
    output busy, done, spr_read_address, fb_write_address, fb_data, fb_we
  );

endinterface

// File: rtl/fb_addr_gen.sv
// Frame-buffer word address y*320 + xw in 19 bits; with BLIT_CLIP_EN defined it
// also flags words that fall outside the screen.
module fb_addr_gen
`ifdef BLIT_CLIP_EN
#(
  parameter int FB_W = blit_pkg::FB_W,
  parameter int FB_H = blit_pkg::FB_H
)
`endif
(
  input  logic [9:0]  y,
  input  logic [9:0]  xw,
  output logic [18:0] addr
`ifdef BLIT_CLIP_EN
  ,
  output logic        clip
`endif
);

  logic [18:0] y_ext;

  assign y_ext = 19'(y);
  // 320 = 256 + 64, so the multiply reduces to two shifts and an add.
  assign addr  = (y_ext << 8) + (y_ext << 6) + 19'(xw);

`ifdef BLIT_CLIP_EN
  assign clip = (int'({xw, 1'b0}) >= FB_W) || (int'(y) >= FB_H);
`endif

endmodule

// File: rtl/sprite_blitter.sv
// Copies a w x h word sprite from sprite RAM into the frame buffer, one word per clock.
// Optional feature macro: BLIT_CLIP_EN (suppresses writes that fall off-screen).
module sprite_blitter
  import blit_pkg::blit_state_t, blit_pkg::blit_tag_t,
         blit_pkg::IDLE, blit_pkg::RUN, blit_pkg::DRAIN, blit_pkg::DONE,
         blit_pkg::BIKE_W_WORDS, blit_pkg::BIKE_H;
#(
  parameter int SPR_MAX_W_WORDS = BIKE_W_WORDS,
  parameter int SPR_MAX_H       = BIKE_H,
  parameter int FB_W            = blit_pkg::FB_W,
  parameter int FB_H            = blit_pkg::FB_H
) (
  input logic             Clk,
  input logic             Reset,
  sprite_blitter_if.slave bus
);

  blit_state_t state, state_next;
  logic        accept;
  logic        zero_size;
  logic        last;
  logic        drain_cnt;

  logic [9:0]  x_lat;
  logic [8:0]  y_lat;
  logic [4:0]  w_lat;
  logic [5:0]  h_lat;
  logic [19:0] rd_addr;
  blit_tag_t   s0, s1;

  logic [9:0]  y_c, xw_c;
  logic [18:0] wr_addr;
  logic        wr_en;

  assign zero_size = (bus.spr_w_words == 5'd0) || (bus.spr_h == 6'd0);
  assign last      = ({1'b0, s0.col} == w_lat - 5'd1) && ({1'b0, s0.row} == h_lat - 6'd1);
  assign bus.spr_read_address = rd_addr;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    state_next = state;
    accept     = 1'b0;
    bus.busy   = (state != IDLE);
    bus.done   = (state == DONE);
    case (state)
      IDLE: if (bus.start) begin
        accept     = 1'b1;
        state_next = zero_size ? DONE : RUN;
      end
      RUN:     if (last) state_next = DRAIN;
      DRAIN:   if (drain_cnt) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign y_c  = 10'(y_lat) + 10'(s1.row);
  assign xw_c = 10'(x_lat >> 1) + 10'(s1.col);

`ifdef BLIT_CLIP_EN
  logic clip;

  fb_addr_gen #(.FB_W(FB_W), .FB_H(FB_H)) u_addr (
    .y(y_c), .xw(xw_c), .addr(wr_addr), .clip(clip)
  );
  assign wr_en = s1.valid && !clip;
`else
  fb_addr_gen u_addr (.y(y_c), .xw(xw_c), .addr(wr_addr));
  assign wr_en = s1.valid;

  // Without clipping the caller owns placement; catch off-screen draws in simulation.
  always_ff @(posedge Clk) begin
    if (!Reset && accept && !zero_size)
      assert (int'(bus.pos_x >> 1) + int'(bus.spr_w_words) <= FB_W / 2 &&
              int'(bus.pos_y) + int'(bus.spr_h) <= FB_H);
  end
`endif

  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (Reset) begin
      x_lat                <= '0;
      y_lat                <= '0;
      w_lat                <= '0;
      h_lat                <= '0;
      rd_addr              <= '0;
      s0                   <= '0;
      s1                   <= '0;
      drain_cnt            <= 1'b0;
      bus.fb_we            <= 1'b0;
      bus.fb_data          <= '0;
      bus.fb_write_address <= '0;
    end else begin
      if (accept) begin
        x_lat    <= bus.pos_x;
        y_lat    <= bus.pos_y;
        w_lat    <= (int'(bus.spr_w_words) > SPR_MAX_W_WORDS) ? 5'(SPR_MAX_W_WORDS) : bus.spr_w_words;
        h_lat    <= (int'(bus.spr_h) > SPR_MAX_H) ? 6'(SPR_MAX_H) : bus.spr_h;
        rd_addr  <= '0;
        s0.valid <= !zero_size;
        s0.row   <= '0;
        s0.col   <= '0;
      end else if (state == RUN) begin
        if (last) begin
          s0.valid <= 1'b0;
        end else begin
          rd_addr <= rd_addr + 20'd1;
          if ({1'b0, s0.col} == w_lat - 5'd1) begin
            s0.col <= '0;
            s0.row <= s0.row + 5'd1;
          end else begin
            s0.col <= s0.col + 4'd1;
          end
        end
      end
      drain_cnt            <= (state == DRAIN) && !drain_cnt;
      // Stage 1 lines up with the registered RAM read; stage 2 issues the write.
      s1                   <= s0;
      bus.fb_we            <= wr_en;
      bus.fb_data          <= bus.spr_data;
      bus.fb_write_address <= wr_addr;
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter against a per-word write-list model.
// Clip scenarios are compiled in when BLIT_CLIP_EN is defined.
module tb_sprite_blitter;
  import blit_pkg::*;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  typedef struct {
    int writes;
    int first_cyc;
    int first_addr;
    int first_data;
    int last_cyc;
    int last_addr;
    int last_data;
    int done_cyc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] key;
  int          tests  = 0;
  int          failed = 0;
  res_t        r;

  always #5 clk = ~clk;

  sprite_blitter_if bus ();

  sprite_blitter dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  // Sprite RAM: one-cycle registered read, word k holds k ^ key.
  always @(posedge clk) bus.spr_data <= bus.spr_read_address[15:0] ^ key;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start a draw at edge 0 and watch cycles 1..end+4. rst_cyc > 0 asserts Reset
  // so that it is sampled at that edge; busy_cyc > 0 pulses a stray start.
  task automatic run_draw(input string name, input int x, input int y, input int w, input int h,
                          input int rst_cyc, input int busy_cyc, output res_t res);
    wr_t q[$];
    int  n, done_cyc, end_cyc, limit, done_cnt;
    bit  exp_we;
    n        = w * h;
    done_cyc = (n == 0) ? 1 : n + 3;
    end_cyc  = (rst_cyc > 0) ? rst_cyc : done_cyc;
    limit    = end_cyc + 4;
    done_cnt = 0;
    res      = '{default: -1};
    res.writes = 0;

    for (int k = 0; k < n; k++) begin
      int row, col, px, py;
      bit keep;
      row  = k / w;
      col  = k % w;
      px   = (x & ~1) + 2 * col;
      py   = y + row;
      keep = 1'b1;
`ifdef BLIT_CLIP_EN
      keep = (px < FB_W) && (py < FB_H);
`endif
      if (keep && (rst_cyc <= 0 || 3 + k <= rst_cyc))
        q.push_back('{cyc: 3 + k,
                      addr: (py * FB_WORDS_PER_ROW + px / 2) % (1 << 19),
                      data: (k ^ int'(key)) & 16'hFFFF});
    end

    @(negedge clk);
    bus.pos_x       = 10'(x);
    bus.pos_y       = 9'(y);
    bus.spr_w_words = 5'(w);
    bus.spr_h       = 6'(h);
    bus.start       = 1'b1;
    @(posedge clk);

    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      check({name, " busy"}, 32'(bus.busy), 32'(c <= end_cyc));
      check({name, " done"}, 32'(bus.done), 32'(rst_cyc <= 0 && c == done_cyc));
      if (bus.done) begin
        done_cnt++;
        res.done_cyc = c;
      end
      if (c <= n && c <= end_cyc)
        check({name, " rd_addr"}, 32'(bus.spr_read_address), 32'(c - 1));

      exp_we = (q.size() > 0) && (q[0].cyc == c);
      check({name, " fb_we"}, 32'(bus.fb_we), 32'(exp_we));
      if (bus.fb_we) begin
        res.writes++;
        if (res.first_cyc < 0) begin
          res.first_cyc  = c;
          res.first_addr = int'(bus.fb_write_address);
          res.first_data = int'(bus.fb_data);
        end
        res.last_cyc  = c;
        res.last_addr = int'(bus.fb_write_address);
        res.last_data = int'(bus.fb_data);
      end
      if (exp_we) begin
        if (bus.fb_we) begin
          check({name, " fb_addr"}, 32'(bus.fb_write_address), 32'(q[0].addr));
          check({name, " fb_data"}, 32'(bus.fb_data), 32'(q[0].data));
        end
        void'(q.pop_front());
      end

      // Controls for the next edge; scrambled inputs must not disturb the draw.
      bus.start = (c == busy_cyc);
      rst       = (c == rst_cyc);
      if (c == 1) begin
        bus.pos_x       = 10'($urandom);
        bus.pos_y       = 9'($urandom);
        bus.spr_w_words = 5'($urandom);
        bus.spr_h       = 6'($urandom);
      end
    end
    bus.start = 1'b0;
    rst       = 1'b0;
    check({name, " done count"}, 32'(done_cnt), 32'((rst_cyc > 0) ? 0 : 1));
    check({name, " missing writes"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int x, y, w, h;
    rst             = 1'b1;
    key             = 16'h0000;
    bus.start       = 1'b0;
    bus.pos_x       = '0;
    bus.pos_y       = '0;
    bus.spr_w_words = '0;
    bus.spr_h       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset fb_we", 32'(bus.fb_we), 32'd0);
    check("reset rd_addr", 32'(bus.spr_read_address), 32'd0);
    check("reset fb_addr", 32'(bus.fb_write_address), 32'd0);
    check("reset fb_data", 32'(bus.fb_data), 32'd0);
    rst = 1'b0;

    run_draw("bike", 100, 50, BIKE_W_WORDS, BIKE_H, 0, 0, r);
    check("bike writes", 32'(r.writes), 32'd512);
    check("bike first cyc", 32'(r.first_cyc), 32'd3);
    check("bike first addr", 32'(r.first_addr), 32'd16050);
    check("bike first data", 32'(r.first_data), 32'h0000);
    check("bike last cyc", 32'(r.last_cyc), 32'd514);
    check("bike last addr", 32'(r.last_addr), 32'd25985);
    check("bike last data", 32'(r.last_data), 32'h01FF);
    check("bike done cyc", 32'(r.done_cyc), 32'd515);

    run_draw("trail", 0, 0, TRAIL_W_WORDS, TRAIL_H, 0, 0, r);
    check("trail writes", 32'(r.writes), 32'd8);
    check("trail last addr", 32'(r.last_addr), 32'd961);
    check("trail done cyc", 32'(r.done_cyc), 32'd11);

    key = 16'h5A3C;
    run_draw("busy start", 10, 20, BIKE_W_WORDS, BIKE_H, 0, 5, r);
    check("busy start writes", 32'(r.writes), 32'd512);
    check("busy start done cyc", 32'(r.done_cyc), 32'd515);

    run_draw("reset mid", 200, 100, BIKE_W_WORDS, BIKE_H, 100, 0, r);
    check("reset mid writes", 32'(r.writes), 32'd98);
    run_draw("after reset", 33, 7, 3, 5, 0, 0, r);
    check("after reset done cyc", 32'(r.done_cyc), 32'd18);

    run_draw("zero w", 40, 40, 0, 7, 0, 0, r);
    check("zero w writes", 32'(r.writes), 32'd0);
    run_draw("zero h", 40, 40, 5, 0, 0, 0, r);
    check("zero h done cyc", 32'(r.done_cyc), 32'd1);

    // start held through done: ignored while DONE, accepted the cycle after.
    @(negedge clk);
    bus.spr_w_words = 5'd0;
    bus.spr_h       = 6'd3;
    bus.start       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hold done c1", 32'(bus.done), 32'd1);
    @(negedge clk);
    check("hold idle c2", 32'({bus.busy, bus.done}), 32'd0);
    @(negedge clk);
    check("hold reaccept c3", 32'({bus.busy, bus.done}), 32'd3);
    bus.start = 1'b0;
    @(negedge clk);
    check("hold idle c4", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      key = 16'($urandom);
      w   = int'($urandom_range(16, 1));
      h   = int'($urandom_range(32, 1));
      x   = int'($urandom_range(640 - 2 * w, 0));
      y   = int'($urandom_range(480 - h, 0));
      run_draw($sformatf("rand%0d", i), x, y, w, h, 0, 0, r);
    end

`ifdef BLIT_CLIP_EN
    run_draw("clip", 624, 470, BIKE_W_WORDS, BIKE_H, 0, 0, r);
    check("clip writes", 32'(r.writes), 32'd80);
    check("clip done cyc", 32'(r.done_cyc), 32'd515);
    for (int i = 0; i < 4; i++) begin
      key = 16'($urandom);
      w   = int'($urandom_range(16, 1));
      h   = int'($urandom_range(32, 1));
      x   = int'($urandom_range(639, 0));
      y   = int'($urandom_range(479, 0));
      run_draw($sformatf("clip rand%0d", i), x, y, w, h, 0, 0, r);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Copies a rectangular sprite (bike 32×32, trail 4×4) from a sprite RAM into the packed frame buffer RAM at a given screen position, one 16-bit word (two 8-bit palette pixels) per clock. Sits between the game-logic FSM, which requests draws, and the frame buffer write port. Its read side drives a sprite RAM, which has 1-cycle registered read latency; its write side drives the frame buffer. The frame buffer is 640×480, with 320 words per row.

## Interface
- `SPR_MAX_W_WORDS`, default 16: maximum sprite width in words (32 pixels).
- `SPR_MAX_H`, default 32: maximum sprite height in rows.
- `FB_W`, default 640: screen width in pixels.
- `FB_H`, default 480: screen height in pixels.

Clock and reset: one clock; reset is synchronous and active-high.

- `Clk`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high reset.
- `start`  in  1  draw request; accepted only in IDLE.
- `pos_x`  in  10  left pixel x; bit 0 ignored (word-aligned).
- `pos_y`  in  9  top pixel y.
- `spr_w_words`  in  5  sprite width in words, 0..16.
- `spr_h`  in  6  sprite height in rows, 0..32.
- `busy`  out  1  high while a draw is in progress.
- `done`  out  1  one-cycle pulse at the end of a draw.
- `spr_read_address`  out  20  sprite RAM read address.
- `spr_data`  in  16  sprite RAM data_Out.
- `fb_write_address`  out  19  frame buffer write address.
- `fb_data`  out  16  frame buffer data_In.
- `fb_we`  out  1  frame buffer write enable.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - On `start`, latch `pos_x`, `pos_y`, `spr_w_words` and `spr_h`; clear the row/col counters and sprite address; go to RUN.
  - If either dimension is 0, go directly to DONE; no writes occur.
- **RUN**
  - Each cycle, present sprite address k (linear, 0..N−1, where N = w·h).
  - col increments; at col = w−1, col wraps to 0 and row increments.
  - After address N−1, go to DRAIN.
- **DRAIN**: stays 2 cycles to flush the pipeline, then goes to DONE.
- **DONE**: `done`=1 for one cycle, then IDLE.
- A 2-stage pipeline carries (row, col, valid) alongside the RAM read.
  - Stage 2 registers `fb_data` = `spr_data` and `fb_write_address` = (pos_y+row)·320 + pos_x[9:1] + col.
  - The ·320 is computed as (y<<8)+(y<<6) in 19 bits.
- Inputs changing after `start` is accepted have no effect. `start` while not IDLE is ignored and not queued.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values:
  - state IDLE.
  - `busy`, `done`, `fb_we` = 0.
  - `spr_read_address`, `fb_write_address`, `fb_data` = 0.
- Counting from the `start` accept edge as cycle 0:
  - sprite address k is valid in cycle 1+k;
  - `spr_data` for word k is valid in cycle 2+k;
  - `fb_we` for word k is high in cycle 3+k.
- `done` is high in cycle N+3; `busy` is high in cycles 1..N+3. Zero-size draw: `done` in cycle 1.
- Throughput is 1 word/clk with no bubbles; `fb_we` is continuous for unclipped draws.
- `Reset` asserted mid-draw: next cycle is IDLE, `fb_we`=0, no `done`. Partial writes already issued stand.
- `done` and an accepted `start` never coincide; a new `start` is accepted in the cycle after `done`.

## Configuration
- `BLIT_CLIP_EN` defined:
  - A word with pixel x (pos_x&~1)+2·col ≥ FB_W, or y pos_y+row ≥ FB_H, has `fb_we` forced 0.
  - Clipped words still consume their cycle, so timing is unchanged.
- `BLIT_CLIP_EN` undefined:
  - No bounds check; the address wraps modulo 2^19.
  - The caller guarantees in-bounds placement.

## Structure
- Package `blit_pkg`:
  - `FB_WORDS_PER_ROW` = 320;
  - `FB_W`, `FB_H`;
  - the `blit_state_t` enum (IDLE, RUN, DRAIN, DONE);
  - sprite size constants: bike 16 words × 32 rows, trail 2 words × 4 rows.
- Sub-module `fb_addr_gen`: combinational y·320 + xw in 19 bits, plus the clip flag when `BLIT_CLIP_EN` is defined.

## Test plan
- **Full bike draw:** 32×32 draw (w=16, h=32) at (100,50) with a behavioural sprite RAM whose word k = k → 512 writes.
  - First write: address 16050, data 0x0000, in cycle 3.
  - Last write: address 25985, data 0x01FF, in cycle 514.
  - `done` in cycle 515.
- **Trail draw:** w=2, h=4 at (0,0) → addresses 0,1,320,321,640,641,960,961; `done` in cycle 11.
- **Clipping:** with `BLIT_CLIP_EN`, 32×32 at (624,470) → exactly 80 writes (words 0..7 of rows 0..9); `done` still in cycle 515.
- **Start while busy:** pulse `start` at cycle 5 of a draw → ignored; exactly one `done`; write count unchanged.
- **Reset mid-draw:** `Reset` at cycle 100 → `fb_we`=0 and `busy`=0 from cycle 101; no `done`; a new `start` is then accepted normally.
- **Zero-size draw:** w=0 → no `fb_we`; `done` in cycle 1.
